// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and helpers for the RV32M sequencer: operation encoding, FSM states and
// operation-class predicates.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mul_op_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL_WAIT,
    DIV_RUN,
    DIV_FIX,
    DONE
  } muldiv_state_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Encoding mirrors funct3: bit 2 separates the divide group from the multiply group.
  function automatic logic is_div_op(mul_op_t op);
    return op[2];
  endfunction

  // True when rs1 is interpreted as signed.
  function automatic logic is_signed_op(mul_op_t op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic is_rem_op(mul_op_t op);
    return op inside {REM, REMU};
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request, response and multiplier-side signals of the M-extension sequencer.
// slave is the controller's view; master is the execute stage plus multiplier.
interface muldiv_ctrl_if #(
  parameter int unsigned XLEN = 32
) ();
  import muldiv_ctrl_pkg::*;

  logic            req_valid;
  logic            req_ready;
  mul_op_t         req_op;
  logic [XLEN-1:0] req_r1;
  logic [XLEN-1:0] req_r2;
  logic [4:0]      req_tag;

  logic            mul_en;
  mul_op_t         mul_op;
  logic [XLEN-1:0] mul_r1;
  logic [XLEN-1:0] mul_r2;
  logic [XLEN-1:0] mul_rd;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic [4:0]      resp_tag;

  modport slave (
    input  req_valid, req_op, req_r1, req_r2, req_tag, mul_rd, resp_ready,
    output req_ready, mul_en, mul_op, mul_r1, mul_r2, resp_valid, resp_data, resp_tag
  );

  modport master (
    output req_valid, req_op, req_r1, req_r2, req_tag, mul_rd, resp_ready,
    input  req_ready, mul_en, mul_op, mul_r1, mul_r2, resp_valid, resp_data, resp_tag
  );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor
// and keep the difference only when it is non-negative.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The extra top bit of diff is the borrow; the remainder itself always fits in XLEN bits.
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (diff[XLEN]) begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between execute and the M-extension: multiplies go to the external registered
// multiplier, divides run in a local 1-bit/cycle restoring divider.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic         clk_n,
  input  logic         rst,
  input  logic         flush,
  muldiv_ctrl_if.slave bus,
  output logic         busy
);

  localparam int unsigned    CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);
  localparam logic [CntW-1:0] MulLast = CntW'(MUL_LAT - 1);
  localparam logic [XLEN-1:0] IntMin  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            quo_neg_q, rem_neg_q, sel_rem_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_data_q;
  logic [4:0]      resp_tag_q;

  logic            req_ready;
  logic            accept;
  logic            op_signed, op_rem, r2_zero, div_ovf;
  logic [XLEN-1:0] abs_r1, abs_r2, special_res, fix_res;
  logic [XLEN-1:0] rem_nxt, quo_nxt;

  assign req_ready     = (state_q == IDLE) && !rst && !flush;
  assign accept        = bus.req_valid && req_ready;
  assign bus.req_ready = req_ready;

  // The multiplier sees operands only in the acceptance cycle; it registers them itself.
  assign bus.mul_en = accept && !is_div_op(bus.req_op);
  assign bus.mul_op = bus.req_op;
  assign bus.mul_r1 = bus.req_r1;
  assign bus.mul_r2 = bus.req_r2;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = resp_tag_q;
  assign busy           = (state_q != IDLE);

  always_comb begin
    op_signed = is_signed_op(bus.req_op);
    op_rem    = is_rem_op(bus.req_op);
    r2_zero   = (bus.req_r2 == '0);
    div_ovf   = op_signed && (bus.req_r1 == IntMin) && (bus.req_r2 == '1);
    // Negating INT_MIN wraps to itself, which is exactly 2^(XLEN-1) read as unsigned.
    abs_r1    = (op_signed && bus.req_r1[XLEN-1]) ? -bus.req_r1 : bus.req_r1;
    abs_r2    = (op_signed && bus.req_r2[XLEN-1]) ? -bus.req_r2 : bus.req_r2;
    if (r2_zero) begin
      special_res = op_rem ? bus.req_r1 : '1;
    end else begin
      special_res = op_rem ? '0 : IntMin;
    end
  end

  always_comb begin
    if (sel_rem_q) begin
      fix_res = rem_neg_q ? -rem_q : rem_q;
    end else begin
      fix_res = quo_neg_q ? -quo_q : quo_q;
    end
  end

  div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_nxt),
    .quo_o     (quo_nxt)
  );

  always_ff @(negedge clk_n) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      quo_neg_q    <= 1'b0;
      rem_neg_q    <= 1'b0;
      sel_rem_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            resp_tag_q <= bus.req_tag;
            cnt_q      <= '0;
            if (!is_div_op(bus.req_op)) begin
              state_q <= MUL_WAIT;
            end else if (r2_zero || div_ovf) begin
              resp_data_q  <= special_res;
              resp_valid_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              rem_q     <= '0;
              quo_q     <= abs_r1;
              dvs_q     <= abs_r2;
              quo_neg_q <= op_signed && (bus.req_r1[XLEN-1] ^ bus.req_r2[XLEN-1]);
              rem_neg_q <= op_signed && bus.req_r1[XLEN-1];
              sel_rem_q <= op_rem;
              state_q   <= DIV_RUN;
            end
          end
        end
        MUL_WAIT: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (cnt_q == MulLast) begin
            resp_data_q  <= bus.mul_rd;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        DIV_RUN: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (cnt_q == DivLast) begin
              cnt_q   <= '0;
              state_q <= DIV_FIX;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        DIV_FIX: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            resp_data_q  <= fix_res;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          // A flush coinciding with the handshake leaves the handshake completed.
          if (flush || bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected results, a monitor pops them
// on every response handshake. The bench also stands in for the registered multiplier.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  typedef struct {
    mul_op_t     op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk_n;
  logic rst;
  logic flush;
  logic busy;
  int   n_chk;
  int   n_fail;
  exp_t exp_q[$];
  vec_t vecs[12];

  muldiv_ctrl_if #(.XLEN(32)) bus ();

  muldiv_ctrl #(
    .XLEN    (32),
    .MUL_LAT (1)
  ) dut (
    .clk_n (clk_n),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk_n = 1'b1;
  always #5 clk_n = ~clk_n;

  function automatic logic [31:0] mul_model(mul_op_t op, logic [31:0] a, logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MUL:     p = sa * sb;
      MULH:    p = (sa * sb) >> 32;
      MULHSU:  p = (sa * ub) >> 32;
      default: p = (ua * ub) >> 32;
    endcase
    return p[31:0];
  endfunction

  // Single-stage registered multiplier model.
  always @(negedge clk_n) begin
    if (bus.mul_en) bus.mul_rd <= mul_model(bus.mul_op, bus.mul_r1, bus.mul_r2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(posedge clk_n) begin
    if (bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got data %h tag %0d, expected no response",
                 bus.resp_data, bus.resp_tag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_data", bus.resp_data, e.data);
        check("resp_tag", {27'b0, bus.resp_tag}, {27'b0, e.tag});
      end
    end
  end

  // Called just after a negedge; returns just after the negedge ending cycle 0.
  task automatic accept_req(input mul_op_t op, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [4:0] tag, input int exp_wait);
    int w;
    w = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_r1    = r1;
    bus.req_r2    = r2;
    bus.req_tag   = tag;
    forever begin
      @(posedge clk_n);
      if (bus.req_ready) break;
      w++;
      if (w > 50) break;
    end
    check("accept_wait", w, exp_wait);
    check("mul_en_cycle0", {31'b0, bus.mul_en}, {31'b0, !is_div_op(op)});
    check("resp_valid_at_accept", {31'b0, bus.resp_valid}, 32'd0);
    @(negedge clk_n);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Counts cycles from cycle 1 until resp_valid; returns at the posedge of that cycle.
  task automatic wait_resp(input int exp_lat);
    int k, bad_busy, bad_mul;
    k = 1;
    bad_busy = 0;
    bad_mul = 0;
    forever begin
      @(posedge clk_n);
      if (!busy) bad_busy++;
      if (bus.mul_en) bad_mul++;
      if (bus.resp_valid) break;
      k++;
      if (k > 100) break;
    end
    check("resp_latency", k, exp_lat);
    check("busy_low_while_active", bad_busy, 0);
    check("mul_en_outside_cycle0", bad_mul, 0);
  endtask

  task automatic issue(input mul_op_t op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] tag, input logic [31:0] exp_data, input int exp_lat,
                       input int exp_wait);
    exp_q.push_back('{data: exp_data, tag: tag});
    accept_req(op, r1, r2, tag, exp_wait);
    wait_resp(exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, seen;
    n_chk  = 0;
    n_fail = 0;
    vecs[0]  = '{MUL,   32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 2};
    vecs[1]  = '{MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[3]  = '{REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[4]  = '{DIVU,  32'd100,      32'd7,        32'd14,       34};
    vecs[5]  = '{REMU,  32'd100,      32'd7,        32'd2,        34};
    vecs[6]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[7]  = '{DIV,   32'h80000000, 32'd2,        32'hC0000000, 34};
    vecs[8]  = '{DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{REM,   32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{REM,   32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

    rst            = 1'b1;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = MUL;
    bus.req_r1     = '0;
    bus.req_r2     = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b1;
    bus.mul_rd     = '0;

    repeat (3) @(negedge clk_n);
    @(posedge clk_n);
    check("reset_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("reset_resp_data", bus.resp_data, 32'd0);
    check("reset_resp_tag", {27'b0, bus.resp_tag}, 32'd0);
    @(negedge clk_n);
    #1;
    rst = 1'b0;
    @(posedge clk_n);
    check("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

    // Directed table, one request at a time with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_n);
      #1;
      issue(vecs[i].op, vecs[i].r1, vecs[i].r2, 5'(i + 1), vecs[i].exp, vecs[i].lat, 0);
    end

    // Backpressure, then a back-to-back request right after the handshake.
    @(negedge clk_n);
    #1;
    bus.resp_ready = 1'b0;
    issue(MUL, 32'd6, 32'd7, 5'd20, 32'd42, 2, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_n);
      if (bus.resp_data !== 32'd42 || bus.resp_tag !== 5'd20) bad++;
      if (bus.req_ready || !bus.resp_valid) bad++;
    end
    check("backpressure_hold", bad, 0);
    @(negedge clk_n);
    #1;
    bus.resp_ready = 1'b1;
    @(negedge clk_n);
    #1;
    issue(DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 34, 0);

    // Flush a divide in cycle 10.
    @(negedge clk_n);
    #1;
    accept_req(DIV, 32'hFFFFFFF9, 32'd2, 5'd22, 0);
    repeat (9) @(negedge clk_n);
    #1;
    flush = 1'b1;
    @(posedge clk_n);
    check("flush_blocks_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk_n);
    #1;
    flush = 1'b0;
    @(posedge clk_n);
    check("flush_div_busy", {31'b0, busy}, 32'd0);
    check("flush_div_ready", {31'b0, bus.req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_n);
      if (bus.resp_valid) seen++;
    end
    check("flush_div_no_resp", seen, 0);

    // Flush a multiply in cycle 1; the late multiplier result must be dropped.
    @(negedge clk_n);
    #1;
    accept_req(MUL, 32'd6, 32'd7, 5'd23, 0);
    flush = 1'b1;
    @(negedge clk_n);
    #1;
    flush = 1'b0;
    seen = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_n);
      if (bus.resp_valid) seen++;
      if (busy) bad++;
    end
    check("flush_mul_no_resp", seen, 0);
    check("flush_mul_idle", bad, 0);

    // Reset during DIV_RUN.
    @(negedge clk_n);
    #1;
    accept_req(DIVU, 32'd100, 32'd7, 5'd24, 0);
    repeat (4) @(negedge clk_n);
    #1;
    rst = 1'b1;
    @(negedge clk_n);
    @(posedge clk_n);
    check("rst_run_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_run_resp_tag", {27'b0, bus.resp_tag}, 32'd0);
    check("rst_run_busy", {31'b0, busy}, 32'd0);
    @(negedge clk_n);
    #1;
    rst = 1'b0;

    // Reset in DONE, with a request held through reset.
    bus.resp_ready = 1'b0;
    @(negedge clk_n);
    #1;
    accept_req(DIVU, 32'd5, 32'd0, 5'd25, 0);
    wait_resp(1);
    check("done_data_before_rst", bus.resp_data, 32'hFFFFFFFF);
    @(negedge clk_n);
    #1;
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = MULHU;
    bus.req_r1    = 32'hFFFFFFFF;
    bus.req_r2    = 32'hFFFFFFFF;
    bus.req_tag   = 5'd26;
    @(posedge clk_n);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_mul_en", {31'b0, bus.mul_en}, 32'd0);
    @(negedge clk_n);
    @(posedge clk_n);
    check("rst_done_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_done_resp_data", bus.resp_data, 32'd0);
    check("rst_done_busy", {31'b0, busy}, 32'd0);
    check("rst_held_not_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk_n);
    #1;
    rst            = 1'b0;
    bus.resp_ready = 1'b1;
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd26, 32'hFFFFFFFE, 2, 0);

    repeat (3) @(negedge clk_n);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
